// File: rtl/synth_pkg.sv
// Shared types and constants for the MCP4921 DAC serialiser.
package synth_pkg;

   localparam int AUDIO_W     = 12;
   localparam int DAC_FRAME_W = 16;

   // MCP4921 write-command configuration bits, frame bits [15:12]
   localparam logic CFG_AB_DACA   = 1'b0;   // 0 = DAC A
   localparam logic CFG_BUF_OFF   = 1'b0;   // 0 = unbuffered VREF
   localparam logic CFG_GA_1X     = 1'b1;   // 1 = 1x gain
   localparam logic CFG_SHDN_RUN  = 1'b1;   // 1 = output active
   localparam logic [3:0] CFG_DEFAULT = {CFG_AB_DACA, CFG_BUF_OFF, CFG_GA_1X, CFG_SHDN_RUN};

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      HOLD  = 3'd3,
      LATCH = 3'd4
   } dac_state_t;

   // Build a write frame: config nibble followed by the sample, passed through verbatim
   function automatic logic [DAC_FRAME_W-1:0] dac_frame(input logic [3:0] cfg,
                                                        input logic [AUDIO_W-1:0] sample);
      return {cfg, sample};
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Modulo-DIV counter with enable and restart; pulse is registered and coincides
// with the last count of each period.
module tick_gen
   import synth_pkg::*;
#(
   parameter int DIV = 4,
   parameter int CW  = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic pulse
);

   localparam logic [CW-1:0] LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          pulse_q, pulse_d;

   // Next count: held at zero when disabled, restarted by clr, wraps at DIV-1
   always_comb begin
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      if (!en) begin
         cnt_d = {CW{1'b0}};
      end else if (clr) begin
         cnt_d = {CW{1'b0}};
      end else if (cnt_q == LAST) begin
         cnt_d = {CW{1'b0}};
      end else begin
         cnt_d = cnt_q + ONE;
      end
      pulse_d = en && (cnt_d == LAST);
   end

   // Count and pulse registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= {CW{1'b0}};
         pulse_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/mcp4921_dac_spi.sv
// Samples the mixed audio bus at a fixed rate and writes each sample to an
// MCP4921 over SPI mode 0,0, then strobes LDAC so the output updates uniformly.
module mcp4921_dac_spi
   import synth_pkg::*;
#(
   parameter int          CLK_DIV    = 4,
   parameter int          SAMPLE_DIV = 1250,
   parameter logic [3:0]  CFG        = CFG_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [AUDIO_W-1:0] audio,
   input  logic               enable,
   output logic               sck,
   output logic               mosi,
   output logic               cs_n,
   output logic               ldac_n,
   output logic               sample_tick,
   output logic               busy,
   output logic               overrun
);

   localparam int SMP_CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int HP_CW  = $clog2(CLK_DIV + 1);

   dac_state_t             state_q, state_d;
   logic [DAC_FRAME_W-1:0] shreg_q, shreg_d;
   logic [3:0]             bit_idx_q, bit_idx_d;
   logic                   sck_q, sck_d;
   logic                   mosi_q, mosi_d;
   logic                   cs_n_q, cs_n_d;
   logic                   ldac_n_q, ldac_n_d;
   logic                   busy_q, busy_d;
   logic                   overrun_q, overrun_d;
   logic                   hp_pulse_s;
   logic                   tick_s;
   logic [DAC_FRAME_W-1:0] frame_s;

   assign frame_s = dac_frame(CFG, audio);

   tick_gen #(.DIV(SAMPLE_DIV), .CW(SMP_CW)) u_sample_timer (
      .clk   (clk),
      .rst   (rst),
      .en    (enable),
      .clr   (1'b0),
      .pulse (tick_s)
   );

   // Half-period timer restarts on every state entry so each phase lasts CLK_DIV cycles
   tick_gen #(.DIV(CLK_DIV), .CW(HP_CW)) u_half_period (
      .clk   (clk),
      .rst   (rst),
      .en    (state_d != IDLE),
      .clr   (state_d != state_q),
      .pulse (hp_pulse_s)
   );

   // Frame sequencer: next state and next values of every registered output
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_idx_d = bit_idx_q;
      sck_d     = sck_q;
      mosi_d    = mosi_q;
      cs_n_d    = cs_n_q;
      ldac_n_d  = ldac_n_q;
      busy_d    = busy_q;
      overrun_d = overrun_q;

      // A tick that lands during a frame is dropped and remembered until reset
      if (tick_s && (state_q != IDLE)) begin
         overrun_d = 1'b1;
      end else begin
         overrun_d = overrun_q;
      end

      case (state_q)
         IDLE: begin
            if (tick_s) begin
               shreg_d = frame_s;
               mosi_d  = frame_s[DAC_FRAME_W-1];
               cs_n_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = SETUP;
            end else begin
               state_d = IDLE;
            end
         end
         SETUP: begin
            if (hp_pulse_s) begin
               sck_d     = 1'b1;
               bit_idx_d = 4'd15;
               state_d   = SHIFT;
            end else begin
               state_d = SETUP;
            end
         end
         SHIFT: begin
            if (!hp_pulse_s) begin
               state_d = SHIFT;
            end else if (sck_q) begin
               // Falling edge: present the next bit, well away from the next rise
               sck_d   = 1'b0;
               mosi_d  = shreg_q[DAC_FRAME_W-2];
               shreg_d = {shreg_q[DAC_FRAME_W-2:0], shreg_q[DAC_FRAME_W-1]};
            end else if (bit_idx_q == 4'd0) begin
               cs_n_d  = 1'b1;
               mosi_d  = 1'b0;
               state_d = HOLD;
            end else begin
               sck_d     = 1'b1;
               bit_idx_d = bit_idx_q - 4'd1;
            end
         end
         HOLD: begin
            if (hp_pulse_s) begin
               ldac_n_d = 1'b0;
               state_d  = LATCH;
            end else begin
               state_d = HOLD;
            end
         end
         LATCH: begin
            if (hp_pulse_s) begin
               ldac_n_d = 1'b1;
               busy_d   = 1'b0;
               state_d  = IDLE;
            end else begin
               state_d = LATCH;
            end
         end
         default: begin
            state_d  = IDLE;
            sck_d    = 1'b0;
            mosi_d   = 1'b0;
            cs_n_d   = 1'b1;
            ldac_n_d = 1'b1;
            busy_d   = 1'b0;
         end
      endcase
   end

   // Sequencer registers; reset aborts any frame without an LDAC strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         shreg_q   <= {DAC_FRAME_W{1'b0}};
         bit_idx_q <= 4'd0;
         sck_q     <= 1'b0;
         mosi_q    <= 1'b0;
         cs_n_q    <= 1'b1;
         ldac_n_q  <= 1'b1;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_idx_q <= bit_idx_d;
         sck_q     <= sck_d;
         mosi_q    <= mosi_d;
         cs_n_q    <= cs_n_d;
         ldac_n_q  <= ldac_n_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
      end
   end

   assign sck         = sck_q;
   assign mosi        = mosi_q;
   assign cs_n        = cs_n_q;
   assign ldac_n      = ldac_n_q;
   assign busy        = busy_q;
   assign overrun     = overrun_q;
   assign sample_tick = tick_s;

endmodule
